// File: rtl/jk_down_interval_timer_pkg.sv
// jk_timer_pkg: shared FSM state encoding and JK cell command codes for the interval timer.
package jk_timer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;
endpackage

// File: rtl/jk_down_interval_timer_jk_ff.sv
// jk_ff: single JK flip-flop with synchronous active-high clear.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_down_interval_timer.sv
// jk_down_interval_timer: loadable down-counting interval timer on JK cells with one-cycle done pulse.
module jk_down_interval_timer
  import jk_timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic done_n, ld, dec;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end
  assign busy = (state == ST_RUN);
  // stop outranks restart, restart outranks decrement and terminal count
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    if (state == ST_IDLE) begin
      ld      = start & ~stop;
      state_n = ld ? ST_RUN : ST_IDLE;
    end else if (stop) state_n = ST_IDLE;
    else if (start) ld = 1'b1;
    else if (en) begin
      if (|count) dec = 1'b1;
      else begin
        done_n  = 1'b1;
        ld      = AUTO_RELOAD;
        state_n = AUTO_RELOAD ? ST_RUN : ST_IDLE;
      end
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic z;
    logic [1:0] cmd;
    if (i == 0) begin : g_lsb
      assign z = 1'b1;
    end else begin : g_upper
      assign z = ~|count[i-1:0];
    end
    assign cmd = ld ? (load_val[i] ? JK_SET : JK_CLR) : (dec & z) ? JK_TOG : JK_HOLD;
    jk_ff u_ff (.clk(clk), .rst(rst), .j(cmd[1]), .k(cmd[0]), .q(count[i]));
  end
endmodule

// File: tb/tb_jk_down_interval_timer.sv
// tb_jk_down_interval_timer: directed steps against one-shot and auto-reload instances with an expectation queue.
module tb_jk_down_interval_timer;
  logic clk = 1'b0;
  logic rst, start0, start1, stop, en;
  logic [3:0] load_val, count0, count1;
  logic busy0, busy1, done0, done1;
  logic [5:0] exp_q[$];
  string tag_q[$];
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  jk_down_interval_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop), .en(en),
    .load_val(load_val), .count(count0), .busy(busy0), .done(done0));
  jk_down_interval_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop), .en(en),
    .load_val(load_val), .count(count1), .busy(busy1), .done(done1));
  task automatic step(input logic r, s, p, e, input logic [3:0] lv, input bit sel,
                      input logic [3:0] ec, input logic eb, ed, input string tag);
    logic [5:0] obs, want;
    string t;
    rst = r;
    start0 = sel ? 1'b0 : s;
    start1 = sel ? s : 1'b0;
    stop = p;
    en = e;
    load_val = lv;
    exp_q.push_back({ec, eb, ed});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs = sel ? {count1, busy1, done1} : {count0, busy0, done0};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: count/busy/done got %0d/%0b/%0b expected %0d/%0b/%0b",
                t, obs[5:2], obs[1], obs[0], want[5:2], want[1], want[0]);
  endtask
  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stop = 1'b0; en = 1'b0; load_val = 4'd0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 1, 0, 0, 9, 0, 9, 1, 0, "rmid_load");
    for (int k = 8; k >= 6; k--) step(0, 0, 0, 1, 9, 0, 4'(k), 1, 0, "rmid_dec");
    step(1, 0, 0, 1, 9, 0, 0, 0, 0, "rmid_rst");
    step(0, 1, 0, 1, 5, 0, 5, 1, 0, "os_load");
    for (int k = 4; k >= 0; k--) step(0, 0, 0, 1, 5, 0, 4'(k), 1, 0, "os_dec");
    step(0, 0, 0, 1, 5, 0, 0, 0, 1, "os_done");
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, "os_after");
    step(0, 1, 0, 0, 3, 0, 3, 1, 0, "gate_load");
    for (int k = 2; k >= 0; k--) begin
      step(0, 0, 0, 0, 3, 0, 4'(k + 1), 1, 0, "gate_hold");
      step(0, 0, 0, 0, 3, 0, 4'(k + 1), 1, 0, "gate_hold");
      step(0, 0, 0, 1, 3, 0, 4'(k), 1, 0, "gate_tick");
    end
    step(0, 0, 0, 0, 3, 0, 0, 1, 0, "gate_hold0");
    step(0, 0, 0, 0, 3, 0, 0, 1, 0, "gate_hold0");
    step(0, 0, 0, 1, 3, 0, 0, 0, 1, "gate_done");
    step(0, 0, 0, 0, 3, 0, 0, 0, 0, "gate_after");
    step(0, 1, 0, 0, 2, 0, 2, 1, 0, "stop_load");
    step(0, 0, 0, 1, 2, 0, 1, 1, 0, "stop_dec");
    step(0, 0, 1, 1, 2, 0, 1, 0, 0, "stop_at1");
    step(0, 0, 0, 1, 2, 0, 1, 0, 0, "idle_hold");
    step(0, 1, 1, 1, 5, 0, 1, 0, 0, "startstop_idle");
    step(0, 0, 1, 1, 5, 0, 1, 0, 0, "stop_idle");
    step(0, 1, 0, 0, 6, 0, 6, 1, 0, "rs_load");
    step(0, 0, 0, 1, 6, 0, 5, 1, 0, "rs_dec");
    step(0, 0, 0, 1, 6, 0, 4, 1, 0, "rs_dec");
    step(0, 1, 0, 1, 7, 0, 7, 1, 0, "restart_at4");
    for (int k = 6; k >= 0; k--) step(0, 0, 0, 1, 7, 0, 4'(k), 1, 0, "rs_run");
    step(0, 1, 0, 1, 3, 0, 3, 1, 0, "restart_at_tc");
    for (int k = 2; k >= 0; k--) step(0, 0, 0, 1, 3, 0, 4'(k), 1, 0, "rs_run2");
    step(0, 1, 1, 1, 3, 0, 0, 0, 0, "stop_beats_tc");
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, "lv0_load");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "lv0_wait");
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, "lv0_done");
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, "lv0_after");
    step(0, 1, 0, 1, 15, 0, 15, 1, 0, "lv15_load");
    for (int k = 14; k >= 0; k--) step(0, 0, 0, 1, 15, 0, 4'(k), 1, 0, "lv15_dec");
    step(0, 0, 0, 1, 15, 0, 0, 0, 1, "lv15_done");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, "ar_reset");
    step(0, 1, 0, 1, 2, 1, 2, 1, 0, "ar_load");
    for (int r = 0; r < 3; r++) begin
      step(0, 0, 0, 1, 2, 1, 1, 1, 0, "ar_dec1");
      step(0, 0, 0, 1, 2, 1, 0, 1, 0, "ar_dec0");
      step(0, 0, 0, 1, 2, 1, 2, 1, 1, "ar_reload");
    end
    step(0, 0, 1, 1, 2, 1, 2, 0, 0, "ar_stop");
    step(0, 1, 0, 1, 0, 1, 0, 1, 0, "ar_lv0_load");
    step(0, 0, 0, 1, 0, 1, 0, 1, 1, "ar_lv0_done");
    step(0, 0, 0, 1, 0, 1, 0, 1, 1, "ar_lv0_done");
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, "ar_lv0_hold");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
